cpu_reset_sequencer: RTL and testbench

- CPU-side consumer of the board's reset/start-address control.
- Holds the 6502 core idle while cpu_reset is high. After release it runs a 6502-style reset sequence: dummy cycles, then either a reset-vector fetch ($FFFC/$FFFD) over a handshaked memory read port, or a direct load of the supplied start_address.
- Ends by pulsing PC/SP load strobes into the core register file, then asserts cpu_run.
- Sits between the program-selection logic and the CPU core / memory arbiter.

---
 rtl/cpu_reset_sequencer.sv | 134 +++++++++++++
 tb/tb_cpu_reset_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reset_sequencer.sv
// 6502-style reset sequencer: holds the core, runs dummy cycles, fetches the
// reset vector (or takes an override address), then strobes PC/SP and runs.
module cpu_reset_sequencer #(
  parameter int          DUMMY_CYCLES  = 5,
  parameter int          READY_TIMEOUT = 255,
  parameter logic [15:0] FALLBACK_PC   = 16'hC000,
  parameter logic [7:0]  SP_INIT       = 8'hFD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_reset,
  input  logic [15:0] start_address,
  input  logic        override_en,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        pc_load,
  output logic [15:0] pc_value,
  output logic        sp_load,
  output logic [7:0]  sp_value,
  output logic        flag_i_set,
  output logic        cpu_run,
  output logic        seq_busy,
  output logic        vec_fault
);

  localparam int DCW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
  localparam int WCW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT + 1) : 1;
  localparam logic [DCW-1:0] DUMMY_INIT = DCW'(DUMMY_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {HOLD, DUMMY, VEC_LO, VEC_HI, LOAD, RUN} state_t;

  state_t         state;
  state_t         next_state;
  logic [DCW-1:0] dummy_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           ovr_q;
  logic [15:0]    start_q;
  logic [7:0]     lo_q;
  logic [15:0]    pc_q;
  logic           fault_q;
  logic           timeout;
  logic [15:0]    load_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HOLD;
    else        state <= next_state;
  end

  // A cpu_reset request beats every handshake outcome, so aborts never load a partial PC.
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      HOLD:   if (!cpu_reset) next_state = DUMMY;
      DUMMY: begin
        if (cpu_reset)              next_state = HOLD;
        else if (dummy_cnt == '0)   next_state = ovr_q ? LOAD : VEC_LO;
      end
      VEC_LO: begin
        if (cpu_reset)                  next_state = HOLD;
        else if (mem_ready)             next_state = VEC_HI;
        else if (wait_cnt == WAIT_LAST) begin
          next_state = LOAD;
          timeout    = 1'b1;
        end
      end
      VEC_HI: begin
        if (cpu_reset)                  next_state = HOLD;
        else if (mem_ready)             next_state = LOAD;
        else if (wait_cnt == WAIT_LAST) begin
          next_state = LOAD;
          timeout    = 1'b1;
        end
      end
      LOAD:    next_state = cpu_reset ? HOLD : RUN;
      RUN:     if (cpu_reset) next_state = HOLD;
      default: next_state = HOLD;
    endcase
  end

  always_comb begin
    if (timeout)             load_pc = FALLBACK_PC;
    else if (state == DUMMY) load_pc = start_q;
    else                     load_pc = {mem_rdata, lo_q};
  end

  // PC and fault flag are latched on the edge into LOAD so they are valid during the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dummy_cnt <= '0;
      wait_cnt  <= '0;
      ovr_q     <= 1'b0;
      start_q   <= '0;
      lo_q      <= '0;
      pc_q      <= FALLBACK_PC;
      fault_q   <= 1'b0;
    end else begin
      if (state == HOLD && !cpu_reset) begin
        ovr_q     <= override_en;
        start_q   <= start_address;
        dummy_cnt <= DUMMY_INIT;
      end else if (state == DUMMY && dummy_cnt != '0) begin
        dummy_cnt <= dummy_cnt - DCW'(1);
      end
      if (next_state != state)
        wait_cnt <= '0;
      else if (state == VEC_LO || state == VEC_HI)
        wait_cnt <= wait_cnt + WCW'(1);
      if (state == VEC_LO && mem_ready)
        lo_q <= mem_rdata;
      if (next_state == LOAD) begin
        pc_q    <= load_pc;
        fault_q <= timeout;
      end
    end
  end

  assign mem_rd     = (state == VEC_LO) || (state == VEC_HI);
  assign mem_addr   = (state == VEC_LO) ? 16'hFFFC :
                      (state == VEC_HI) ? 16'hFFFD : 16'h0000;
  assign pc_load    = (state == LOAD);
  assign sp_load    = (state == LOAD);
  assign flag_i_set = (state == LOAD);
  assign cpu_run    = (state == RUN);
  assign seq_busy   = (state == DUMMY) || (state == VEC_LO) ||
                      (state == VEC_HI) || (state == LOAD);
  assign pc_value   = pc_q;
  assign sp_value   = SP_INIT;
  assign vec_fault  = fault_q;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Self-checking bench for cpu_reset_sequencer: table vectors, random boots
// against a timing/value model, plus abort and async-reset sequences.
module tb_cpu_reset_sequencer;

  localparam int D     = 5;
  localparam int T     = 255;
  localparam int BOUND = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_reset;
  logic [15:0] start_address;
  logic        override_en;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        pc_load;
  logic [15:0] pc_value;
  logic        sp_load;
  logic [7:0]  sp_value;
  logic        flag_i_set;
  logic        cpu_run;
  logic        seq_busy;
  logic        vec_fault;

  logic [7:0]  vec_lo;
  logic [7:0]  vec_hi;
  int          mem_wait;
  bit          mem_stall;
  int          wcount = 0;
  logic [15:0] reads_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    bit          ovr;
    logic [15:0] start;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          wait_n;
    bit          stall;
    int          exp_load;
    logic [15:0] exp_pc;
    int          exp_reads;
    int          exp_rd;
    bit          exp_fault;
  } vec_t;

  typedef struct packed {
    int          load_cyc;
    int          loads;
    int          run_cyc;
    int          rd_cycles;
    int          reads;
    logic [15:0] pc;
    logic [15:0] pc_after;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [7:0]  sp;
    logic        flag;
    logic        spl;
    logic        fault_start;
    logic        fault_end;
    logic        unstable;
    logic        busy1;
  } obs_t;

  cpu_reset_sequencer #(
    .DUMMY_CYCLES (D),
    .READY_TIMEOUT(T),
    .FALLBACK_PC  (16'hC000),
    .SP_INIT      (8'hFD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_reset    (cpu_reset),
    .start_address(start_address),
    .override_en  (override_en),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pc_load      (pc_load),
    .pc_value     (pc_value),
    .sp_load      (sp_load),
    .sp_value     (sp_value),
    .flag_i_set   (flag_i_set),
    .cpu_run      (cpu_run),
    .seq_busy     (seq_busy),
    .vec_fault    (vec_fault)
  );

  always #5 clk = ~clk;

  // Vector memory: answers after mem_wait idle cycles, or never when stalled.
  assign mem_ready = mem_rd && !mem_stall && (wcount == mem_wait);
  assign mem_rdata = (mem_addr == 16'hFFFD) ? vec_hi : vec_lo;

  always @(posedge clk) begin
    if (mem_rd && mem_ready) begin
      reads_q.push_back(mem_addr);
      wcount <= 0;
    end else if (mem_rd) begin
      wcount <= wcount + 1;
    end else begin
      wcount <= 0;
    end
  end

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input bit ovr, input logic [15:0] start, input logic [7:0] lo,
                              input logic [7:0] hi, input int wait_n, input bit stall,
                              input int exp_load, input logic [15:0] exp_pc,
                              input int exp_reads, input int exp_rd, input bit exp_fault);
    vec_t v;
    v.ovr = ovr; v.start = start; v.lo = lo; v.hi = hi; v.wait_n = wait_n; v.stall = stall;
    v.exp_load = exp_load; v.exp_pc = exp_pc; v.exp_reads = exp_reads;
    v.exp_rd = exp_rd; v.exp_fault = exp_fault;
    return v;
  endfunction

  // Reference: boot latency is dummy phase, plus memory phase, plus one; PC source by priority.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    int   mem_cycles;
    e = v;
    mem_cycles  = v.ovr ? 0 : (v.stall ? T : 2 * (v.wait_n + 1));
    e.exp_load  = D + 1 + mem_cycles;
    e.exp_rd    = mem_cycles;
    e.exp_reads = (v.ovr || v.stall) ? 0 : 2;
    e.exp_pc    = v.ovr ? v.start : (v.stall ? 16'hC000 : {v.hi, v.lo});
    e.exp_fault = !v.ovr && v.stall;
    return e;
  endfunction

  // Runs one boot: release (cpu_reset or rst_n), then observe until one cycle into RUN.
  task automatic applyStimulus(input vec_t v, input bit release_rst, output obs_t o);
    bit          prev_wait;
    logic [15:0] prev_addr;
    o = '0;
    prev_wait = 1'b0;
    prev_addr = '0;
    if (!release_rst) begin
      @(negedge clk);
      cpu_reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
    override_en   = v.ovr;
    start_address = v.start;
    vec_lo        = v.lo;
    vec_hi        = v.hi;
    mem_wait      = v.wait_n;
    mem_stall     = v.stall;
    reads_q.delete();
    if (release_rst) rst_n = 1'b1;
    else             cpu_reset = 1'b0;
    for (int k = 1; k <= BOUND; k++) begin
      @(negedge clk);
      if (k == 1) begin
        o.fault_start = vec_fault;
        o.busy1       = seq_busy;
        override_en   = ~v.ovr;
        start_address = ~v.start;
      end
      if (mem_rd) o.rd_cycles = o.rd_cycles + 1;
      if (prev_wait && mem_rd && mem_addr != prev_addr) o.unstable = 1'b1;
      prev_wait = mem_rd && !mem_ready;
      prev_addr = mem_addr;
      if (pc_load) begin
        o.loads = o.loads + 1;
        if (o.loads == 1) begin
          o.load_cyc = k;
          o.pc       = pc_value;
          o.sp       = sp_value;
          o.flag     = flag_i_set;
          o.spl      = sp_load;
        end
      end
      if (cpu_run && o.run_cyc == 0) o.run_cyc = k;
      if (o.run_cyc != 0 && k >= o.run_cyc + 1) break;
    end
    o.reads = reads_q.size();
    if (reads_q.size() > 0) o.addr0 = reads_q[0];
    if (reads_q.size() > 1) o.addr1 = reads_q[1];
    o.fault_end = vec_fault;
    o.pc_after  = pc_value;
  endtask

  task automatic checkOutput(input string tag, input vec_t e, input obs_t o, input bit fault_before);
    checkValue({tag, ".busy_cycle1"}, o.busy1, 1);
    checkValue({tag, ".fault_before_load"}, o.fault_start, fault_before);
    checkValue({tag, ".pc_load_cycle"}, o.load_cyc, e.exp_load);
    checkValue({tag, ".pc_load_pulses"}, o.loads, 1);
    checkValue({tag, ".pc_value"}, o.pc, e.exp_pc);
    checkValue({tag, ".sp_value"}, o.sp, 8'hFD);
    checkValue({tag, ".sp_load"}, o.spl, 1);
    checkValue({tag, ".flag_i_set"}, o.flag, 1);
    checkValue({tag, ".run_cycle"}, o.run_cyc, e.exp_load + 1);
    checkValue({tag, ".mem_rd_cycles"}, o.rd_cycles, e.exp_rd);
    checkValue({tag, ".reads"}, o.reads, e.exp_reads);
    if (e.exp_reads == 2) begin
      checkValue({tag, ".read0_addr"}, o.addr0, 16'hFFFC);
      checkValue({tag, ".read1_addr"}, o.addr1, 16'hFFFD);
    end
    checkValue({tag, ".addr_stable"}, o.unstable, 0);
    checkValue({tag, ".vec_fault"}, o.fault_end, e.exp_fault);
    checkValue({tag, ".pc_hold"}, o.pc_after, e.exp_pc);
  endtask

  // Pulses rst_n low mid-cycle while running; leaves rst_n low at a falling edge.
  task automatic asyncResetCheck(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkValue({tag, ".cpu_run"}, cpu_run, 0);
    checkValue({tag, ".pc_load"}, pc_load, 0);
    checkValue({tag, ".sp_load"}, sp_load, 0);
    checkValue({tag, ".flag_i_set"}, flag_i_set, 0);
    checkValue({tag, ".mem_rd"}, mem_rd, 0);
    checkValue({tag, ".seq_busy"}, seq_busy, 0);
    checkValue({tag, ".sp_value"}, sp_value, 8'hFD);
    checkValue({tag, ".pc_value"}, pc_value, 16'hC000);
    checkValue({tag, ".vec_fault"}, vec_fault, 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        table_v[5];
    vec_t        v;
    obs_t        o;
    bit          model_fault;
    logic [15:0] last_pc;
    int          seen_load;

    rst_n = 1'b0; cpu_reset = 1'b1; override_en = 1'b0; start_address = '0;
    vec_lo = '0; vec_hi = '0; mem_wait = 0; mem_stall = 1'b0;

    //            ovr   start     lo     hi   wait stall load pc        reads rd  fault
    table_v[0] = mk(1'b0, 16'h0000, 8'h34, 8'hC0, 0, 1'b0, 8,   16'hC034, 2, 2,   1'b0);
    table_v[1] = mk(1'b1, 16'hC060, 8'h34, 8'hC0, 0, 1'b0, 6,   16'hC060, 0, 0,   1'b0);
    table_v[2] = mk(1'b0, 16'h0000, 8'h78, 8'h12, 3, 1'b0, 14,  16'h1278, 2, 8,   1'b0);
    table_v[3] = mk(1'b0, 16'h4444, 8'h55, 8'h66, 0, 1'b1, 261, 16'hC000, 0, 255, 1'b1);
    table_v[4] = mk(1'b0, 16'h0000, 8'h00, 8'h80, 1, 1'b0, 10,  16'h8000, 2, 4,   1'b0);

    @(negedge clk);
    @(negedge clk);
    checkValue("reset.cpu_run", cpu_run, 0);
    checkValue("reset.pc_load", pc_load, 0);
    checkValue("reset.mem_rd", mem_rd, 0);
    checkValue("reset.mem_addr", mem_addr, 16'h0000);
    checkValue("reset.seq_busy", seq_busy, 0);
    checkValue("reset.sp_value", sp_value, 8'hFD);
    checkValue("reset.pc_value", pc_value, 16'hC000);
    checkValue("reset.vec_fault", vec_fault, 0);
    rst_n = 1'b1;

    model_fault = 1'b0;
    last_pc     = 16'hC000;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(table_v[i], 1'b0, o);
      checkOutput($sformatf("vec%0d", i), table_v[i], o, model_fault);
      model_fault = table_v[i].exp_fault;
      last_pc     = table_v[i].exp_pc;
    end

    for (int i = 0; i < 8; i++) begin
      v        = '0;
      v.ovr    = 1'($urandom_range(0, 1));
      v.start  = 16'($urandom);
      v.lo     = 8'($urandom);
      v.hi     = 8'($urandom);
      v.wait_n = $urandom_range(0, 4);
      v.stall  = ($urandom_range(0, 5) == 0);
      v        = model(v);
      applyStimulus(v, 1'b0, o);
      checkOutput($sformatf("rand%0d", i), v, o, model_fault);
      model_fault = v.exp_fault;
      last_pc     = v.exp_pc;
    end

    // Abort in the second cycle of the high-byte read.
    @(negedge clk);
    cpu_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    override_en = 1'b0; vec_lo = 8'h11; vec_hi = 8'h22; mem_wait = 3; mem_stall = 1'b0;
    cpu_reset = 1'b0;
    seen_load = 0;
    for (int k = 1; k <= D + 6; k++) begin
      @(negedge clk);
      if (pc_load) seen_load = seen_load + 1;
    end
    checkValue("abort.vec_hi_rd", mem_rd, 1);
    checkValue("abort.vec_hi_addr", mem_addr, 16'hFFFD);
    cpu_reset = 1'b1;
    @(negedge clk);
    checkValue("abort.mem_rd", mem_rd, 0);
    checkValue("abort.seq_busy", seq_busy, 0);
    checkValue("abort.cpu_run", cpu_run, 0);
    checkValue("abort.pc_value", pc_value, last_pc);
    for (int k = 0; k < 4; k++) begin
      if (pc_load) seen_load = seen_load + 1;
      @(negedge clk);
    end
    checkValue("abort.no_pc_load", seen_load, 0);
    applyStimulus(table_v[0], 1'b0, o);
    checkOutput("after_abort", table_v[0], o, model_fault);
    model_fault = 1'b0;

    asyncResetCheck("arst_run");
    applyStimulus(table_v[2], 1'b1, o);
    checkOutput("after_arst", table_v[2], o, 1'b0);

    applyStimulus(table_v[3], 1'b0, o);
    checkOutput("fault_again", table_v[3], o, 1'b0);
    asyncResetCheck("arst_fault");
    applyStimulus(table_v[1], 1'b1, o);
    checkOutput("after_arst2", table_v[1], o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
